// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared constants for the uDLX memory stage.
//   LW_OPCODE / SW_OPCODE : load/store opcodes (same values as the execute stage)
//   WORD_OFFSET_W         : byte-offset bits below a word address
//   is_word_aligned()     : true when the byte offset of an address is zero
package memory_access_pkg;

  localparam int unsigned OPCODE_W      = 6;
  localparam int unsigned WORD_OFFSET_W = 2;

  localparam logic [OPCODE_W-1:0] LW_OPCODE = 6'h23;
  localparam logic [OPCODE_W-1:0] SW_OPCODE = 6'h2b;

  function automatic logic is_word_aligned(input logic [WORD_OFFSET_W-1:0] lsb);
    return (lsb == WORD_OFFSET_W'(0));
  endfunction

endpackage

// File: rtl/mem_wb_register.sv
// mem_wb_register: MEM/WB pipeline register.
//   clk, rst          : clock, asynchronous active-high reset
//   load_i            : retire strobe; produces a one-cycle wb_valid_o pulse
//   reg_wr_en_i, reg_wr_addr_i, data_i : writeback fields captured on load_i
//   wb_valid_o, wb_reg_wr_en_o, wb_reg_wr_addr_o, wb_data_o : registered outputs;
//   the fields hold until the next load.
module mem_wb_register #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic                      reg_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      wb_valid_o,
  output logic                      wb_reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o
);

  logic                      valid_q;
  logic                      wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]     data_q;

  // Valid is a pulse; payload fields are sticky between retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      data_q    <= '0;
    end else begin
      valid_q <= load_i;
      if (load_i) begin
        wr_en_q   <= reg_wr_en_i;
        wr_addr_q <= reg_wr_addr_i;
        data_q    <= data_i;
      end
    end
  end

  assign wb_valid_o       = valid_q;
  assign wb_reg_wr_en_o   = wr_en_q;
  assign wb_reg_wr_addr_o = wr_addr_q;
  assign wb_data_o        = data_q;

endmodule

// File: rtl/memory_access.sv
// memory_access: uDLX memory stage.
// Non-memory instructions retire through the MEM/WB register one cycle after
// acceptance. LW/SW run a single outstanding req/ack transaction on the data
// memory port and stall execute (ex_ready=0) until the ack.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   ex_valid / ex_ready           : execute handshake (ex_ready decodes state only)
//   ex_opcode, ex_alu_result, ex_store_data, ex_reg_wr_en, ex_reg_wr_addr : instruction
//   dmem_req/we/addr/wdata        : registered memory request, stable until ack
//   dmem_ack, dmem_rdata          : memory completion and load data
//   wb_valid, wb_reg_wr_en, wb_reg_wr_addr, wb_data : writeback
// Build option MEM_ALIGN_CHECK_EN: adds mem_misalign_err; misaligned LW/SW
// retire immediately without a request. When undefined, dmem_addr[1:0] is
// forced to zero and every LW/SW issues a request.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned OPCODE_WIDTH   = 6,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [OPCODE_WIDTH-1:0]   ex_opcode,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic                      ex_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic                      wb_reg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_addr,
  output logic [DATA_WIDTH-1:0]     wb_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                      mem_misalign_err
`endif
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e                    state_q;
  logic                      dmem_req_q;
  logic                      dmem_we_q;
  logic [ADDR_WIDTH-1:0]     dmem_addr_q;
  logic [DATA_WIDTH-1:0]     dmem_wdata_q;
  logic                      lat_wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] lat_wr_addr_q;

  logic                      accept;
  logic                      is_lw;
  logic                      is_sw;
  logic                      is_mem;
  logic                      misalign;
  logic                      mem_done;
  logic [ADDR_WIDTH-1:0]     req_addr;

  logic                      wb_load_c;
  logic                      wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_d;

  assign ex_ready = (state_q == ST_IDLE);
  assign accept   = ex_valid & ex_ready;
  assign is_lw    = (ex_opcode == OPCODE_WIDTH'(LW_OPCODE));
  assign is_sw    = (ex_opcode == OPCODE_WIDTH'(SW_OPCODE));
  assign is_mem   = is_lw | is_sw;
  assign mem_done = (state_q == ST_ACCESS) & dmem_ack;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem & ~is_word_aligned(ex_alu_result[WORD_OFFSET_W-1:0]);
  assign req_addr = ex_alu_result[ADDR_WIDTH-1:0];
`else
  // Word-addressed port: byte offset is dropped rather than trapped.
  assign misalign = 1'b0;
  assign req_addr = {ex_alu_result[ADDR_WIDTH-1:WORD_OFFSET_W], WORD_OFFSET_W'(0)};
`endif

  // Retire selection: pass-through, misaligned drop, or memory completion.
  always_comb begin
    wb_load_c = 1'b0;
    wb_en_d   = 1'b0;
    wb_addr_d = lat_wr_addr_q;
    wb_data_d = '0;
    if (accept) begin
      if (!is_mem) begin
        wb_load_c = 1'b1;
        wb_en_d   = ex_reg_wr_en;
        wb_addr_d = ex_reg_wr_addr;
        wb_data_d = ex_alu_result;
      end else if (misalign) begin
        wb_load_c = 1'b1;
        wb_addr_d = ex_reg_wr_addr;
      end
    end else if (mem_done) begin
      wb_load_c = 1'b1;
      if (!dmem_we_q) begin
        wb_en_d   = lat_wr_en_q;
        wb_data_d = dmem_rdata;
      end
    end
  end

  // Request FSM; request fields are captured on accept and held through ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      lat_wr_en_q   <= 1'b0;
      lat_wr_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && is_mem && !misalign) begin
            state_q       <= ST_ACCESS;
            dmem_req_q    <= 1'b1;
            dmem_we_q     <= is_sw;
            dmem_addr_q   <= req_addr;
            dmem_wdata_q  <= ex_store_data;
            lat_wr_en_q   <= ex_reg_wr_en;
            lat_wr_addr_q <= ex_reg_wr_addr;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            state_q    <= ST_IDLE;
            dmem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_err_q;

  // One-cycle error pulse, coincident with the dropped instruction's wb_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= accept & misalign;
    end
  end

  assign mem_misalign_err = misalign_err_q;
`endif

  mem_wb_register #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_mem_wb (
    .clk              (clk),
    .rst              (rst),
    .load_i           (wb_load_c),
    .reg_wr_en_i      (wb_en_d),
    .reg_wr_addr_i    (wb_addr_d),
    .data_i           (wb_data_d),
    .wb_valid_o       (wb_valid),
    .wb_reg_wr_en_o   (wb_reg_wr_en),
    .wb_reg_wr_addr_o (wb_reg_wr_addr),
    .wb_data_o        (wb_data)
  );

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed scenarios plus randomized instruction stream for
// memory_access, checked every cycle against a transaction-level model.
// Build option MEM_ALIGN_CHECK_EN selects the alignment-check variant.
module tb_memory_access;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned OW = 6;
  localparam int unsigned RW = 5;

  localparam logic [OW-1:0] OP_LW   = 6'h23;
  localparam logic [OW-1:0] OP_SW   = 6'h2b;
  localparam logic [OW-1:0] OP_ADDI = 6'h08;
  localparam logic [OW-1:0] OP_ALU  = 6'h00;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          ex_valid;
  logic          ex_ready;
  logic [OW-1:0] ex_opcode;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_store_data;
  logic          ex_reg_wr_en;
  logic [RW-1:0] ex_reg_wr_addr;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid;
  logic          wb_reg_wr_en;
  logic [RW-1:0] wb_reg_wr_addr;
  logic [DW-1:0] wb_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic          mem_misalign_err;
`endif

  memory_access #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .OPCODE_WIDTH   (OW),
    .REG_ADDR_WIDTH (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_opcode      (ex_opcode),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_reg_wr_en   (ex_reg_wr_en),
    .ex_reg_wr_addr (ex_reg_wr_addr),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_reg_wr_en   (wb_reg_wr_en),
    .wb_reg_wr_addr (wb_reg_wr_addr),
    .wb_data        (wb_data)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_misalign_err (mem_misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- memory responder ----------------
  int            force_delay   = -1;
  bit            force_rdata_en = 1'b0;
  logic [DW-1:0] force_rdata   = '0;
  int            stray_mode    = 0;   // 0 none, 1 random, 2 always
  bit            mbusy         = 1'b0;
  int            mcnt          = 0;

  always @(posedge clk) begin
    #1;
    if (dmem_req) begin
      if (!mbusy) begin
        mbusy = 1'b1;
        mcnt  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
      end else begin
        mcnt--;
      end
      dmem_ack   = (mcnt == 0);
      dmem_rdata = force_rdata_en ? force_rdata : DW'($urandom);
    end else begin
      mbusy      = 1'b0;
      dmem_ack   = (stray_mode == 2) ? 1'b1 :
                   (stray_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      dmem_rdata = DW'($urandom);
    end
  end

  // ---------------- transaction-level model ----------------
  bit            m_busy;
  bit            m_is_load;
  bit            m_en;
  logic [RW-1:0] m_dst;
  bit            e_req, e_we, e_wbv, e_wben, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_wbdata;
  logic [RW-1:0] e_wbaddr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_is_load = 0; m_en = 0; m_dst = '0;
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_wbv = 0; e_wben = 0; e_wbaddr = '0; e_wbdata = '0; e_err = 0;
    end else begin
      e_wbv = 0;
      e_err = 0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (ex_opcode == OP_LW || ex_opcode == OP_SW) begin
            if (ALIGN && (ex_alu_result % 4 != 0)) begin
              e_wbv = 1; e_wben = 0; e_wbaddr = ex_reg_wr_addr; e_wbdata = '0; e_err = 1;
            end else begin
              m_busy    = 1;
              m_is_load = (ex_opcode == OP_LW);
              m_en      = ex_reg_wr_en;
              m_dst     = ex_reg_wr_addr;
              e_req     = 1;
              e_we      = (ex_opcode == OP_SW);
              e_addr    = ALIGN ? ex_alu_result : (ex_alu_result / 4) * 4;
              e_wdata   = ex_store_data;
            end
          end else begin
            e_wbv = 1; e_wben = ex_reg_wr_en; e_wbaddr = ex_reg_wr_addr; e_wbdata = ex_alu_result;
          end
        end
      end else if (dmem_ack) begin
        m_busy   = 0;
        e_req    = 0;
        e_wbv    = 1;
        e_wben   = m_is_load ? m_en : 1'b0;
        e_wbaddr = m_dst;
        e_wbdata = m_is_load ? dmem_rdata : '0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_ready", 64'(ex_ready), 64'(!m_busy));
      check("dmem_req", 64'(dmem_req), 64'(e_req));
      if (e_req) begin
        check("dmem_we",    64'(dmem_we),    64'(e_we));
        check("dmem_addr",  64'(dmem_addr),  64'(e_addr));
        check("dmem_wdata", 64'(dmem_wdata), 64'(e_wdata));
      end
      check("wb_valid",       64'(wb_valid),       64'(e_wbv));
      check("wb_reg_wr_en",   64'(wb_reg_wr_en),   64'(e_wben));
      check("wb_reg_wr_addr", 64'(wb_reg_wr_addr), 64'(e_wbaddr));
      check("wb_data",        64'(wb_data),        64'(e_wbdata));
`ifdef MEM_ALIGN_CHECK_EN
      check("mem_misalign_err", 64'(mem_misalign_err), 64'(e_err));
`endif
    end
  end

  // Retirement log for ordering checks.
  logic [DW-1:0] wb_log[$];
  always @(negedge clk) if (wb_valid) wb_log.push_back(wb_data);

  // ---------------- driver ----------------
  task automatic send(input logic [OW-1:0] op, input logic [DW-1:0] alu,
                      input logic [DW-1:0] sd, input logic en, input logic [RW-1:0] dst,
                      output longint acc_t);
    bit rdy;
    bit done;
    done  = 1'b0;
    acc_t = 0;
    ex_valid = 1'b1; ex_opcode = op; ex_alu_result = alu;
    ex_store_data = sd; ex_reg_wr_en = en; ex_reg_wr_addr = dst;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      rdy = ex_ready;
      @(posedge clk);
      if (rdy) begin
        done  = 1'b1;
        acc_t = longint'($time);
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL accept_timeout: got no ex_ready expected accept within 60 cycles");
    end
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    longint t0, t1, t2;
    logic [OW-1:0] op;
    logic [DW-1:0] alu;
    int r;

    rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_alu_result = '0;
    ex_store_data = '0; ex_reg_wr_en = 1'b0; ex_reg_wr_addr = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data",  64'(wb_data),  64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // ADDI r3 <- 0x10
    send(OP_ADDI, 32'h10, 32'h0, 1'b1, 5'd3, t0);
    idle();
    @(negedge clk);
    check("addi_wb_valid", 64'(wb_valid),       64'd1);
    check("addi_wb_data",  64'(wb_data),        64'h10);
    check("addi_wb_addr",  64'(wb_reg_wr_addr), 64'd3);
    check("addi_wb_en",    64'(wb_reg_wr_en),   64'd1);
    check("addi_no_req",   64'(dmem_req),       64'd0);
    @(posedge clk); #1;

    // LW 0x100, ack on the third request cycle
    force_delay = 2; force_rdata_en = 1'b1; force_rdata = 32'hDEAD_BEEF;
    send(OP_LW, 32'h100, 32'h0, 1'b1, 5'd7, t0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lw_req",   64'(dmem_req),  64'd1);
      check("lw_addr",  64'(dmem_addr), 64'h100);
      check("lw_we",    64'(dmem_we),   64'd0);
      check("lw_ready", 64'(ex_ready),  64'd0);
      check("lw_no_wb", 64'(wb_valid),  64'd0);
    end
    @(negedge clk);
    check("lw_wb_valid", 64'(wb_valid),       64'd1);
    check("lw_wb_data",  64'(wb_data),        64'hDEAD_BEEF);
    check("lw_wb_addr",  64'(wb_reg_wr_addr), 64'd7);
    check("lw_wb_en",    64'(wb_reg_wr_en),   64'd1);
    check("lw_ready_back", 64'(ex_ready),     64'd1);
    @(posedge clk); #1;

    // SW 0x204 <- 0x1234, ack in the first request cycle
    force_delay = 0;
    send(OP_SW, 32'h204, 32'h1234, 1'b1, 5'd9, t0);
    idle();
    @(negedge clk);
    check("sw_req",   64'(dmem_req),   64'd1);
    check("sw_we",    64'(dmem_we),    64'd1);
    check("sw_addr",  64'(dmem_addr),  64'h204);
    check("sw_wdata", 64'(dmem_wdata), 64'h1234);
    check("sw_no_wb", 64'(wb_valid),   64'd0);
    @(negedge clk);
    check("sw_wb_valid", 64'(wb_valid),     64'd1);
    check("sw_wb_en",    64'(wb_reg_wr_en), 64'd0);
    check("sw_wb_data",  64'(wb_data),      64'd0);
    @(posedge clk); #1;

    // Back-to-back ADD, LW, ADD with ex_valid held high
    force_delay = 1; force_rdata = 32'hCAFE_0001;
    wb_log.delete();
    send(OP_ALU, 32'h11, 32'h0, 1'b1, 5'd1, t0);
    send(OP_LW,  32'h40, 32'h0, 1'b1, 5'd2, t1);
    send(OP_ALU, 32'h22, 32'h0, 1'b1, 5'd4, t2);
    idle();
    repeat (3) @(negedge clk);
    check("b2b_lw_after_add", 64'(t1 - t0), 64'd10);
    check("b2b_add_after_lw", 64'(t2 - t1), 64'd30);
    check("b2b_count", 64'(wb_log.size()), 64'd3);
    if (wb_log.size() == 3) begin
      check("b2b_wb0", 64'(wb_log[0]), 64'h11);
      check("b2b_wb1", 64'(wb_log[1]), 64'hCAFE_0001);
      check("b2b_wb2", 64'(wb_log[2]), 64'h22);
    end
    @(posedge clk); #1;

    // Reset during ACCESS, then stray acks
    force_delay = 20;
    send(OP_LW, 32'h300, 32'h0, 1'b1, 5'd5, t0);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_req_before", 64'(dmem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req_drop", 64'(dmem_req), 64'd0);
    check("rst_mid_ready",    64'(ex_ready), 64'd1);
    check("rst_mid_no_wb",    64'(wb_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_log.delete();
    force_delay = -1; stray_mode = 2;
    repeat (8) @(negedge clk);
    check("stray_no_wb",  64'(wb_log.size()), 64'd0);
    check("stray_no_req", 64'(dmem_req),      64'd0);
    stray_mode = 0;
    @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned LW is dropped without a request
    send(OP_LW, 32'h102, 32'h0, 1'b1, 5'd6, t0);
    idle();
    @(negedge clk);
    check("mis_no_req",   64'(dmem_req),         64'd0);
    check("mis_err",      64'(mem_misalign_err), 64'd1);
    check("mis_wb_valid", 64'(wb_valid),         64'd1);
    check("mis_wb_en",    64'(wb_reg_wr_en),     64'd0);
    @(negedge clk);
    check("mis_err_pulse", 64'(mem_misalign_err), 64'd0);
    check("mis_wb_pulse",  64'(wb_valid),         64'd0);
    @(posedge clk); #1;
`endif

    // Randomized instruction stream
    force_rdata_en = 1'b0; force_delay = -1; stray_mode = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
      r = int'($urandom_range(0, 9));
      if (r < 3) op = OP_LW;
      else if (r < 6) op = OP_SW;
      else begin
        op = OW'($urandom_range(0, 63));
        while (op == OP_LW || op == OP_SW) op = OW'($urandom_range(0, 63));
      end
      alu = DW'($urandom);
      if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      send(op, alu, DW'($urandom), 1'($urandom), RW'($urandom), t0);
    end
    idle();
    stray_mode = 0;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
